// File: rtl/selection_save_if.sv
// Purpose : bundles the menu-selection handshake between the selector/button
//           side (master) and the save controller (slave).
// Signals : confirm_in  raw confirm button, active-low, asynchronous
//           sel_in      current selector value (legal 1..2)
//           guardado    1 = selector may change, 0 = frozen during a save
//           saved_sel   last saved selection
//           save_pulse  one-cycle strobe, saved_sel valid in the same cycle
//           busy        1 while a save is in progress
interface selection_save_if #(
  parameter int SEL_W = 2
);
  logic             confirm_in;
  logic [SEL_W-1:0] sel_in;
  logic             guardado;
  logic [SEL_W-1:0] saved_sel;
  logic             save_pulse;
  logic             busy;

  modport master (
    output confirm_in, sel_in,
    input  guardado, saved_sel, save_pulse, busy
  );

  modport slave (
    input  confirm_in, sel_in,
    output guardado, saved_sel, save_pulse, busy
  );
endinterface

// File: rtl/selection_save_controller.sv
// Purpose : responder side of the menu-selection handshake. Synchronises and
//           debounces the active-low confirm button; on a confirmed press with
//           a legal selector value it latches sel_in, strobes save_pulse and
//           holds guardado low for a lockout window that also waits for the
//           button to be released.
// Ports   : clk    system clock
//           reset  synchronous reset, active-high
//           bus    selection_save_if.slave (confirm_in, sel_in in;
//                  guardado, saved_sel, save_pulse, busy out)
module selection_save_controller #(
  parameter int N              = 11,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int SEL_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  selection_save_if.slave  bus
);

  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, LOCKOUT} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [N-1:0]     db_cnt_q;
  logic             db_level_q, db_prev_q;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [SEL_W-1:0] sel_cap_q, sel_cap_d;
  logic [SEL_W-1:0] saved_sel_q, saved_sel_d;
  logic             guardado_q, guardado_d;
  logic             save_pulse_q, save_pulse_d;
  logic             busy_q, busy_d;
  logic             press_evt, sel_ok;

  // Synchroniser and debouncer. The counter saturates once its MSB is set,
  // and only then does the debounced level follow the synchronised input.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
      db_prev_q  <= 1'b1;
    end else begin
      s1_q <= bus.confirm_in;
      s2_q <= s1_q;
      if (s1_q != s2_q)        db_cnt_q <= '0;
      else if (!db_cnt_q[N-1]) db_cnt_q <= db_cnt_q + 1'b1;
      if (db_cnt_q[N-1])       db_level_q <= s2_q;
      db_prev_q <= db_level_q;
    end
  end

  // Button is active-low: a press is the 1->0 edge of the debounced level.
  assign press_evt = db_prev_q & ~db_level_q;
  assign sel_ok    = (bus.sel_in == SEL_W'(1)) || (bus.sel_in == SEL_W'(2));

  // Outputs are a registered function of the current state, so the pulse
  // appears one cycle after CAPTURE is entered (two after press_evt).
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    sel_cap_d    = sel_cap_q;
    saved_sel_d  = saved_sel_q;
    guardado_d   = 1'b1;
    save_pulse_d = 1'b0;
    busy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // sel_in is sampled only here; illegal values drop the press.
        if (press_evt && sel_ok) begin
          state_d   = CAPTURE;
          sel_cap_d = bus.sel_in;
        end
      end
      CAPTURE: begin
        saved_sel_d  = sel_cap_q;
        save_pulse_d = 1'b1;
        guardado_d   = 1'b0;
        busy_d       = 1'b1;
        lock_cnt_d   = LW'(LOCKOUT_CYCLES - 1);
        state_d      = LOCKOUT;
      end
      LOCKOUT: begin
        guardado_d = 1'b0;
        busy_d     = 1'b1;
        // Count to zero, then also wait for the debounced release so a
        // held button cannot retrigger a save.
        if (lock_cnt_q != '0)  lock_cnt_d = lock_cnt_q - 1'b1;
        else if (db_level_q)   state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      sel_cap_q    <= SEL_W'(1);
      saved_sel_q  <= SEL_W'(1);
      guardado_q   <= 1'b1;
      save_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      sel_cap_q    <= sel_cap_d;
      saved_sel_q  <= saved_sel_d;
      guardado_q   <= guardado_d;
      save_pulse_q <= save_pulse_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.guardado   = guardado_q;
  assign bus.saved_sel  = saved_sel_q;
  assign bus.save_pulse = save_pulse_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_selection_save_controller.sv
module tb_selection_save_controller;
  localparam int N    = 4;
  localparam int LOCK = 16;
  localparam int D    = 1 << (N - 1);

  logic clk;
  logic reset;
  selection_save_if #(.SEL_W(2)) bus();

  selection_save_controller #(.N(N), .LOCKOUT_CYCLES(LOCK), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;

  // Reference model: a save is "idle / capturing / locked out", and the
  // debounced level takes the raw value once D+1 consecutive raw samples
  // (seen through the two-stage synchroniser delay) agree.
  int         ph;
  int         tmr;
  logic [1:0] cap;
  logic       lvl_cur, lvl_prev;
  logic       h[$];
  logic       e_guard, e_pulse, e_busy;
  logic [1:0] e_saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic evt, stable;
    int sz;
    if (reset) begin
      ph = 0; tmr = 0; cap = 2'd1;
      lvl_cur = 1'b1; lvl_prev = 1'b1;
      h.delete(); h.push_back(1'b1); h.push_back(1'b1);
      e_guard = 1'b1; e_saved = 2'd1; e_pulse = 1'b0; e_busy = 1'b0;
    end else begin
      evt     = lvl_prev & ~lvl_cur;
      e_pulse = (ph == 1);
      e_guard = (ph == 0);
      e_busy  = (ph != 0);
      if (ph == 1) e_saved = cap;
      case (ph)
        0: if (evt && (bus.sel_in == 2'd1 || bus.sel_in == 2'd2)) begin
             ph = 1; cap = bus.sel_in;
           end
        1: begin ph = 2; tmr = LOCK - 1; end
        default: if (tmr > 0) tmr--; else if (lvl_cur) ph = 0;
      endcase
      h.push_back(bus.confirm_in);
      sz = h.size();
      lvl_prev = lvl_cur;
      if (sz >= D + 3) begin
        stable = 1'b1;
        for (int i = sz - 3 - D; i <= sz - 3; i++)
          if (h[i] !== h[sz-3]) stable = 1'b0;
        if (stable) lvl_cur = h[sz-3];
      end
      if (sz > 40) void'(h.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("guardado", {31'd0, bus.guardado}, {31'd0, e_guard});
    chk("saved_sel", {30'd0, bus.saved_sel}, {30'd0, e_saved});
    chk("save_pulse", {31'd0, bus.save_pulse}, {31'd0, e_pulse});
    chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
    if (bus.save_pulse) pulses++;
  endtask

  task automatic drive(input logic c, input logic [1:0] s, input int n);
    bus.confirm_in = c;
    bus.sel_in     = s;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_guard(input string tag, output int at);
    int n;
    n = 0;
    while (!bus.guardado && n < 300) begin tick(); n++; end
    chk(tag, {31'd0, bus.guardado}, 32'd1);
    at = cyc;
  endtask

  initial begin
    int p0, t0, tp, tg, drops;
    logic [1:0] sv;
    logic seen;

    // 1: reset with an unknown button
    reset = 1'b1; bus.confirm_in = 1'bx; bus.sel_in = 2'd1;
    tick();
    chk("rst_guardado", {31'd0, bus.guardado}, 32'd1);
    chk("rst_saved_sel", {30'd0, bus.saved_sel}, 32'd1);
    chk("rst_pulse", {31'd0, bus.save_pulse}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    drive(1'b1, 2'd1, 12);

    // 2: clean press with sel 2
    p0 = pulses; t0 = cyc; tp = -1; sv = 2'd0; seen = 1'b0;
    bus.confirm_in = 1'b0; bus.sel_in = 2'd2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.save_pulse && tp < 0) begin
        tp = cyc; sv = bus.saved_sel; seen = !bus.guardado;
      end
    end
    chk("clean_one_pulse", pulses - p0, 32'd1);
    chk("clean_latency", {31'd0, (tp > t0) && (tp - t0 <= D + 6)}, 32'd1);
    chk("clean_saved", {30'd0, sv}, 32'd2);
    chk("clean_guard_low", {31'd0, seen}, 32'd1);
    bus.confirm_in = 1'b1;
    wait_guard("clean_release", tg);
    chk("clean_lockout_len", {31'd0, (tg - tp) >= LOCK}, 32'd1);
    drive(1'b1, 2'd2, 5);

    // 3: bouncing button, then a settled press with sel 1
    p0 = pulses;
    for (int i = 0; i < 10; i++) drive(i[0], 2'd1, 3);
    chk("bounce_no_pulse", pulses - p0, 32'd0);
    drive(1'b0, 2'd1, 30);
    chk("bounce_one_pulse", pulses - p0, 32'd1);
    chk("bounce_saved", {30'd0, bus.saved_sel}, 32'd1);
    bus.confirm_in = 1'b1;
    wait_guard("bounce_release", tg);
    drive(1'b1, 2'd1, 5);

    // 4: held button, then a re-press
    p0 = pulses; drops = 0; seen = 1'b0;
    bus.confirm_in = 1'b0; bus.sel_in = 2'd2;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.save_pulse) seen = 1'b1;
      if (seen && !bus.busy) drops++;
    end
    chk("held_one_pulse", pulses - p0, 32'd1);
    chk("held_busy_drops", drops, 32'd0);
    chk("held_saved", {30'd0, bus.saved_sel}, 32'd2);
    bus.confirm_in = 1'b1;
    wait_guard("held_release", tg);
    drive(1'b1, 2'd1, 5);
    p0 = pulses;
    drive(1'b0, 2'd1, 20);
    chk("repress_pulse", pulses - p0, 32'd1);
    chk("repress_saved", {30'd0, bus.saved_sel}, 32'd1);
    bus.confirm_in = 1'b1;
    wait_guard("repress_release", tg);
    drive(1'b1, 2'd1, 5);

    // 5: illegal selector value
    p0 = pulses; drops = 0;
    bus.confirm_in = 1'b0; bus.sel_in = 2'd3;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!bus.guardado) drops++;
    end
    chk("illegal_no_pulse", pulses - p0, 32'd0);
    chk("illegal_guard_low", drops, 32'd0);
    chk("illegal_saved", {30'd0, bus.saved_sel}, 32'd1);
    drive(1'b1, 2'd1, 15);

    // 6: reset in the middle of lockout
    p0 = pulses;
    bus.confirm_in = 1'b0; bus.sel_in = 2'd2;
    for (int i = 0; i < 30 && pulses == p0; i++) tick();
    chk("midrst_pulse", pulses - p0, 32'd1);
    drive(1'b1, 2'd2, 4);
    reset = 1'b1;
    tick();
    chk("midrst_guardado", {31'd0, bus.guardado}, 32'd1);
    chk("midrst_saved", {30'd0, bus.saved_sel}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 2'd1, 5);

    // 7: random button runs and selector values against the model
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(1, 25));
    drive(1'b1, 2'd1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
